writeback_arbiter: RTL

Shares the single output-memory write port among NUM_REQ allocator result streams. It replaces the scheduler's single-allocator writeback_en hack. Each requester hands over a (result, output-index) pair through a valid/ready handshake. The block buffers one pair per requester, grants the write port round-robin, counts completed writes and raises a sticky done when the expected number of outputs for the (image, filter) pair has been written.

---
 rtl/writeback_arbiter_pkg.sv | 12 +
 rtl/rr_priority_picker.sv | 32 +++
 rtl/writeback_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Constants and state encoding shared by the writeback path and the memory blocks.
package writeback_arbiter_pkg;

  localparam int DATA_W = 18;
  localparam int ADDR_W = 16;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } wb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set bit of i_valid found by
// scanning upward from i_rr_ptr, wrapping modulo NUM_REQ.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_grant_idx,
  output logic               o_any
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = PTR_W'((int'(i_rr_ptr) + off) % NUM_REQ);
      if (!o_any && i_valid[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the output-memory write port among NUM_REQ result streams: one buffered
// slot per requester, round-robin grants, write counting and sticky completion.
module writeback_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = writeback_arbiter_pkg::DATA_W,
  parameter int ADDR_W  = writeback_arbiter_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [ADDR_W-1:0]         expected_count,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         out_mem_data,
  output logic [ADDR_W-1:0]         out_mem_addr,
  output logic                      out_mem_en,
  output logic [ADDR_W-1:0]         write_count,
  output logic                      done,
  output logic                      overflow
);

  import writeback_arbiter_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] r_slot_valid;
  logic [DATA_W-1:0]  r_slot_data [NUM_REQ];
  logic [ADDR_W-1:0]  r_slot_addr [NUM_REQ];
  logic [PTR_W-1:0]   r_rr_ptr;
  wb_state_e          r_state;
  wb_state_e          w_state_next;
  logic               r_out_en;
  logic [DATA_W-1:0]  r_out_data;
  logic [ADDR_W-1:0]  r_out_addr;
  logic [ADDR_W-1:0]  r_write_count;
  logic               r_overflow;

  logic [NUM_REQ-1:0] w_ready;
  logic [NUM_REQ-1:0] w_capture;
  logic [NUM_REQ-1:0] w_pick_valid;
  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_grant_idx;
  logic [PTR_W-1:0]   w_ptr_next;
  logic               w_grant_any;
  logic [ADDR_W-1:0]  w_count_inc;

  // Ready depends only on registered state, never on req_valid.
  assign w_ready      = ~r_slot_valid & {NUM_REQ{r_state == RUN}};
  assign w_capture    = req_valid & w_ready;
  assign w_pick_valid = r_slot_valid & {NUM_REQ{r_state == RUN}};
  assign w_count_inc  = r_write_count + ADDR_W'(1);
  assign w_ptr_next   = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + PTR_W'(1);

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_valid     (w_pick_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_grant_any)
  );

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = RUN;
    end else if (r_state == RUN && w_grant_any && expected_count != '0
                 && w_count_inc == expected_count) begin
      w_state_next = DONE;
    end
  end

  // NOTE: <= in every clocked block so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  // NOTE: slot payload has no reset; only the valid bit qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_capture[i]) begin
        r_slot_data[i] <= req_data[i*DATA_W +: DATA_W];
        r_slot_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_valid  <= '0;
      r_rr_ptr      <= '0;
      r_out_en      <= 1'b0;
      r_out_data    <= '0;
      r_out_addr    <= '0;
      r_write_count <= '0;
      r_overflow    <= 1'b0;
    end else if (clear) begin
      r_slot_valid  <= '0;
      r_rr_ptr      <= '0;
      r_out_en      <= 1'b0;
      r_out_data    <= '0;
      r_out_addr    <= '0;
      r_write_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_out_en <= w_grant_any;
      if (w_grant_any) begin
        r_out_data    <= r_slot_data[w_grant_idx];
        r_out_addr    <= r_slot_addr[w_grant_idx];
        r_rr_ptr      <= w_ptr_next;
        r_write_count <= w_count_inc;
      end
      // A granted slot was not ready, so grant and capture never hit the same bit.
      r_slot_valid <= (r_slot_valid & ~w_grant) | w_capture;
      if ((w_grant_any && (&r_write_count) && expected_count != '0) ||
          (r_state == DONE && (|req_valid))) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign req_ready    = w_ready;
  assign out_mem_en   = r_out_en;
  assign out_mem_data = r_out_data;
  assign out_mem_addr = r_out_addr;
  assign write_count  = r_write_count;
  assign done         = (r_state == DONE);
  assign overflow     = r_overflow;

endmodule
